// File: rtl/pri_enc_queue.sv
// rtl/pri_enc_queue.sv - registered priority encoder queue with fixed/round-robin grant
module pri_enc_queue #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         rr_en,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    output logic         pend_any,
    output logic         drop
);

    logic [N-1:0] pending_q, pending_d, clr;
    logic [W-1:0] out_idx_q, out_idx_d;
    logic [W-1:0] last_grant_q, last_grant_d;
    logic [W-1:0] sel_fixed, sel_rr, sel, cand;
    logic         out_valid_q, out_valid_d;
    logic         drop_q, drop_d;
    logic         load, grant;

    always_comb begin
        sel_fixed = '0;
        for (int i = 0; i < N; i++) begin
            if (pending_q[i]) sel_fixed = W'(i);
        end
    end

    // Scan from farthest to nearest so the first set bit after last_grant wins.
    always_comb begin
        sel_rr = '0;
        cand   = '0;
        for (int k = N; k >= 1; k--) begin
            cand = last_grant_q + W'(k);
            if (pending_q[cand]) sel_rr = cand;
        end
    end

    always_comb begin
        sel          = rr_en ? sel_rr : sel_fixed;
        load         = ~out_valid_q | out_ready;
        grant        = load & (|pending_q);
        clr          = grant ? (N'(1) << sel) : '0;
        pending_d    = (pending_q & ~clr) | req;
        drop_d       = |(req & pending_q & ~clr);
        out_idx_d    = grant ? sel : out_idx_q;
        last_grant_d = grant ? sel : last_grant_q;
        out_valid_d  = load ? grant : out_valid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q    <= '0;
            out_idx_q    <= '0;
            out_valid_q  <= 1'b0;
            drop_q       <= 1'b0;
            last_grant_q <= W'(N - 1);
        end else begin
            pending_q    <= pending_d;
            out_idx_q    <= out_idx_d;
            out_valid_q  <= out_valid_d;
            drop_q       <= drop_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_idx   = out_idx_q;
    assign out_valid = out_valid_q;
    assign pend_any  = |pending_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_pri_enc_queue.sv
// tb/tb_pri_enc_queue.sv - directed vector bench for pri_enc_queue (N=4 and N=8)
module tb_pri_enc_queue;

    typedef struct {
        logic [3:0] req;
        logic       rr;
        logic       rdy;
        logic       v;
        logic [1:0] idx;
        logic       pa;
        logic       dr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req4;
    logic       rr4, rdy4;
    logic [1:0] idx4;
    logic       v4, pa4, dr4;
    logic [7:0] req8;
    logic       rr8, rdy8;
    logic [2:0] idx8;
    logic       v8, pa8, dr8;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl[$];

    pri_enc_queue #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .rr_en(rr4), .out_ready(rdy4),
        .out_idx(idx4), .out_valid(v4), .pend_any(pa4), .drop(dr4)
    );

    pri_enc_queue #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .rr_en(rr8), .out_ready(rdy8),
        .out_idx(idx8), .out_valid(v8), .pend_any(pa8), .drop(dr8)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic v, input logic [2:0] idx,
                         input logic pa, input logic dr, input logic ev,
                         input logic [2:0] eidx, input logic epa, input logic edr);
        n_vec++;
        if (v !== ev || idx !== eidx || pa !== epa || dr !== edr) begin
            n_err++;
            $display("FAIL %s: got valid=%b idx=%0d pend_any=%b drop=%b, want valid=%b idx=%0d pend_any=%b drop=%b",
                     name, v, idx, pa, dr, ev, eidx, epa, edr);
        end
    endtask

    task automatic run(input int lo, input int hi, input string tag);
        for (int i = lo; i <= hi; i++) begin
            req4 = tbl[i].req;
            rr4  = tbl[i].rr;
            rdy4 = tbl[i].rdy;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", tag, i), v4, {1'b0, idx4}, pa4, dr4,
                  tbl[i].v, {1'b0, tbl[i].idx}, tbl[i].pa, tbl[i].dr);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req4  = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // req, rr, rdy | valid, idx, pend_any, drop
        // fixed priority drain of 0011
        tbl.push_back('{4'b0011, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0});
        // backpressure with a dropped repeat on bit 0
        tbl.push_back('{4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{4'b0001, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1});
        tbl.push_back('{4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0});
        tbl.push_back('{4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0});
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0});
        // round robin with all requests held (after reset)
        tbl.push_back('{4'b1111, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{4'b1111, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1});
        tbl.push_back('{4'b1111, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1});
        tbl.push_back('{4'b1111, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1});
        tbl.push_back('{4'b1111, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1});
        tbl.push_back('{4'b1111, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1});
        tbl.push_back('{4'b1111, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1});
        // set beats clear on the granted bit (after reset)
        tbl.push_back('{4'b1000, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{4'b1000, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0});
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0});
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0});

        req4 = '0; rr4 = 1'b0; rdy4 = 1'b0;
        req8 = '0; rr8 = 1'b0; rdy8 = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset4", v4, {1'b0, idx4}, pa4, dr4, 1'b0, 3'd0, 1'b0, 1'b0);
        check("reset8", v8, idx8, pa8, dr8, 1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run(0, 11, "fixed");
        do_reset();
        run(12, 18, "rr");
        do_reset();
        run(19, 22, "setclr");

        // asynchronous reset between edges, then RR restarts from index 0
        do_reset();
        req4 = 4'b0111; rr4 = 1'b1; rdy4 = 1'b0;
        @(negedge clk);
        req4 = 4'b0000;
        @(negedge clk);
        req4 = 4'b0010;
        @(posedge clk);
        #1;
        check("pre_rst", v4, {1'b0, idx4}, pa4, dr4, 1'b1, 3'd0, 1'b1, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst", v4, {1'b0, idx4}, pa4, dr4, 1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        req4  = 4'b1001; rr4 = 1'b1; rdy4 = 1'b1;
        @(negedge clk);
        req4 = 4'b0000;
        @(posedge clk);
        #1;
        check("rr_after_rst", v4, {1'b0, idx4}, pa4, dr4, 1'b1, 3'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("rr_after_rst2", v4, {1'b0, idx4}, pa4, dr4, 1'b1, 3'd3, 1'b0, 1'b0);

        // N=8 fixed priority
        @(negedge clk);
        req8 = 8'b0100_1000; rr8 = 1'b0; rdy8 = 1'b1;
        @(posedge clk);
        #1;
        check("n8_cap", v8, idx8, pa8, dr8, 1'b0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        req8 = '0;
        @(posedge clk);
        #1;
        check("n8_g6", v8, idx8, pa8, dr8, 1'b1, 3'd6, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("n8_g3", v8, idx8, pa8, dr8, 1'b1, 3'd3, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("n8_idle", v8, idx8, pa8, dr8, 1'b0, 3'd3, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
